// File: rtl/frame_config_loader.sv
// frame_config_loader
//   Bitstream configuration loader feeding the tile ConfigMems. Waits for a
//   sync word, then repeatedly parses a frame header (column/frame address),
//   assembles NumberOfRows data words onto FrameData and fires a one-cycle
//   one-hot FrameStrobe at the addressed column/frame. A header whose column
//   field equals DesyncCol closes the session.
//
// Ports
//   CLK          system clock, rising edge
//   RESET        asynchronous active-high reset
//   WriteData    bitstream word
//   WriteStrobe  WriteData valid; word accepted on WriteStrobe && Ready
//   Ready        loader can accept a word (low only in STROBE)
//   FrameData    assembled frame, row r at [r*FrameBitsPerRow +: FrameBitsPerRow]
//   FrameStrobe  one-hot latch pulse, bit col*MaxFramesPerCol + frame
//   ConfigActive session open (any state other than IDLE)
//   ConfigError  sticky out-of-range address flag, cleared on sync
//
// state  | meaning
// -------+-------------------------------------------------------------
// IDLE   | hunting for SyncWord, all other words discarded
// HEADER | next accepted word is a frame header or the desync header
// DATA   | collecting row words 0..NumberOfRows-1
// STROBE | one cycle: FrameStrobe pulse (if address valid), Ready low

module frame_config_loader #(
  parameter int          FrameBitsPerRow = 32,
  parameter int          MaxFramesPerCol = 20,
  parameter int          NumberOfRows    = 4,
  parameter int          NumberOfCols    = 4,
  parameter logic [31:0] SyncWord        = 32'hFAB0_FAB1,
  parameter logic [7:0]  DesyncCol       = 8'hFF
) (
  input  logic                                    CLK,
  input  logic                                    RESET,
  input  logic [FrameBitsPerRow-1:0]              WriteData,
  input  logic                                    WriteStrobe,
  output logic                                    Ready,
  output logic [FrameBitsPerRow*NumberOfRows-1:0] FrameData,
  output logic [MaxFramesPerCol*NumberOfCols-1:0] FrameStrobe,
  output logic                                    ConfigActive,
  output logic                                    ConfigError
);

  localparam int ROW_W   = (NumberOfRows > 1) ? $clog2(NumberOfRows) : 1;
  localparam int DATA_W  = FrameBitsPerRow * NumberOfRows;
  localparam int STB_W   = MaxFramesPerCol * NumberOfCols;
  localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(NumberOfRows - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    HEADER = 2'd1,
    DATA   = 2'd2,
    STROBE = 2'd3
  } state_t;

  state_t             state_q, state_d;
  logic [7:0]         col_q, col_d;
  logic [7:0]         frame_q, frame_d;
  logic [ROW_W-1:0]   row_q, row_d;
  logic [DATA_W-1:0]  frame_data_q, frame_data_d;
  logic [STB_W-1:0]   frame_strobe_q, frame_strobe_d;
  logic               config_error_q, config_error_d;

  logic               ready;
  logic               accept;
  logic [STB_W-1:0]   addr_hit;

  assign ready  = (state_q != STROBE);
  assign accept = WriteStrobe && ready;

  // Decode the latched address into the one-hot strobe vector. An
  // out-of-range column or frame matches no bit, so the vector stays zero.
  always_comb begin
    addr_hit = '0;
    for (int c = 0; c < NumberOfCols; c++) begin
      for (int f = 0; f < MaxFramesPerCol; f++) begin
        addr_hit[c*MaxFramesPerCol + f] = (col_q == 8'(c)) && (frame_q == 8'(f));
      end
    end
  end

  always_comb begin
    state_d        = state_q;
    col_d          = col_q;
    frame_d        = frame_q;
    row_d          = row_q;
    frame_data_d   = frame_data_q;
    frame_strobe_d = '0;
    config_error_d = config_error_q;

    case (state_q)
      IDLE: begin
        if (accept && (WriteData == SyncWord)) begin
          state_d        = HEADER;
          config_error_d = 1'b0;
        end
      end

      HEADER: begin
        if (accept) begin
          if (WriteData[31:24] == DesyncCol) begin
            state_d = IDLE;
          end else begin
            col_d   = WriteData[31:24];
            frame_d = WriteData[23:16];
            row_d   = '0;
            state_d = DATA;
          end
        end
      end

      DATA: begin
        if (accept) begin
          for (int r = 0; r < NumberOfRows; r++) begin
            if (row_q == ROW_W'(r)) begin
              frame_data_d[r*FrameBitsPerRow +: FrameBitsPerRow] = WriteData;
            end
          end
          if (row_q == LAST_ROW) begin
            // Strobe is registered so it appears exactly during STROBE.
            state_d        = STROBE;
            frame_strobe_d = addr_hit;
            if (addr_hit == '0) begin
              config_error_d = 1'b1;
            end
          end else begin
            row_d = row_q + 1'b1;
          end
        end
      end

      STROBE: begin
        state_d = HEADER;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q        <= IDLE;
      col_q          <= '0;
      frame_q        <= '0;
      row_q          <= '0;
      frame_data_q   <= '0;
      frame_strobe_q <= '0;
      config_error_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      col_q          <= col_d;
      frame_q        <= frame_d;
      row_q          <= row_d;
      frame_data_q   <= frame_data_d;
      frame_strobe_q <= frame_strobe_d;
      config_error_q <= config_error_d;
    end
  end

  assign Ready        = ready;
  assign FrameData    = frame_data_q;
  assign FrameStrobe  = frame_strobe_q;
  assign ConfigActive = (state_q != IDLE);
  assign ConfigError  = config_error_q;

endmodule

// File: tb/tb_frame_config_loader.sv
// tb_frame_config_loader
//   Directed stimulus for frame_config_loader. The driver pushes the expected
//   strobe vector, frame contents and strobe cycle into a scoreboard queue;
//   a monitor pops and compares whenever FrameStrobe is non-zero. Status
//   outputs are checked directly at the points where their value is known.

module tb_frame_config_loader;

  logic         CLK = 1'b0;
  logic         RESET;
  logic [31:0]  WriteData;
  logic         WriteStrobe;
  logic         Ready;
  logic [127:0] FrameData;
  logic [79:0]  FrameStrobe;
  logic         ConfigActive;
  logic         ConfigError;

  frame_config_loader dut (
    .CLK          (CLK),
    .RESET        (RESET),
    .WriteData    (WriteData),
    .WriteStrobe  (WriteStrobe),
    .Ready        (Ready),
    .FrameData    (FrameData),
    .FrameStrobe  (FrameStrobe),
    .ConfigActive (ConfigActive),
    .ConfigError  (ConfigError)
  );

  always #5 CLK = ~CLK;

  int cyc    = 0;
  int checks = 0;
  int errors = 0;
  int last_strobe_cyc = -1;
  int prev_strobe_cyc = -1;

  always @(posedge CLK) cyc <= cyc + 1;

  typedef struct {
    logic [79:0]  strobe;
    logic [127:0] data;
    int           at;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: every non-zero FrameStrobe must match the oldest expectation.
  always @(negedge CLK) begin
    if (!RESET && FrameStrobe != '0) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_strobe: got %h expected none at cycle %0d", FrameStrobe, cyc);
      end else begin
        mon_e = sb.pop_front();
        check("strobe_vector", {48'd0, FrameStrobe}, {48'd0, mon_e.strobe});
        check("strobe_frame_data", FrameData, mon_e.data);
        check("strobe_cycle", 128'(cyc), 128'(mon_e.at));
        check("ready_in_strobe", {127'd0, Ready}, 128'd0);
      end
      prev_strobe_cyc = last_strobe_cyc;
      last_strobe_cyc = cyc;
    end
  end

  // Present a word and hold it until accepted. Starts and ends on a negedge.
  task automatic send(input logic [31:0] w);
    int  n;
    logic r;
    n = 0;
    WriteData   = w;
    WriteStrobe = 1'b1;
    forever begin
      r = Ready;
      @(posedge CLK);
      @(negedge CLK);
      if (r) break;
      n++;
      if (n > 20) begin
        checks++;
        errors++;
        $display("FAIL send_timeout: got no accept expected accept of %h", w);
        break;
      end
    end
  endtask

  task automatic idle(input int n);
    WriteStrobe = 1'b0;
    repeat (n) @(negedge CLK);
  endtask

  // Header + four rows; idx < 0 means no strobe is expected.
  task automatic frame(input logic [31:0] hdr, input logic [31:0] d0, input logic [31:0] d1,
                       input logic [31:0] d2, input logic [31:0] d3, input int idx);
    exp_t e;
    send(hdr);
    send(d0);
    send(d1);
    send(d2);
    if (idx >= 0) begin
      e.strobe      = '0;
      e.strobe[idx] = 1'b1;
      e.data        = {d3, d2, d1, d0};
      e.at          = cyc + 1;
      sb.push_back(e);
    end
    send(d3);
  endtask

  initial begin
    RESET       = 1'b1;
    WriteData   = '0;
    WriteStrobe = 1'b0;
    repeat (2) @(negedge CLK);
    check("reset_frame_data", FrameData, 128'd0);
    check("reset_strobe", {48'd0, FrameStrobe}, 128'd0);
    check("reset_active", {127'd0, ConfigActive}, 128'd0);
    check("reset_error", {127'd0, ConfigError}, 128'd0);
    check("reset_ready", {127'd0, Ready}, 128'd1);
    RESET = 1'b0;
    @(negedge CLK);

    // Garbage before sync is discarded.
    for (int i = 0; i < 3; i++) begin
      send(32'hDEAD_BEEF);
      check("garbage_inactive", {127'd0, ConfigActive}, 128'd0);
    end
    send(32'hFAB0_FAB1);
    check("sync_active", {127'd0, ConfigActive}, 128'd1);

    // Basic frame: col 2 frame 3 -> bit 43.
    frame(32'h0203_0000, 32'h1111_1111, 32'h2222_2222, 32'h3333_3333, 32'h4444_4444, 43);
    idle(2);
    check("frame1_seen", 128'(last_strobe_cyc >= 0), 128'd1);
    check("frame1_data_hold", FrameData, 128'h44444444_33333333_22222222_11111111);

    // Column out of range.
    frame(32'h0500_0000, 32'h0000_0001, 32'h0000_0002, 32'h0000_0003, 32'h0000_0004, -1);
    check("col_oor_strobe", {48'd0, FrameStrobe}, 128'd0);
    check("col_oor_error", {127'd0, ConfigError}, 128'd1);
    check("col_oor_ready", {127'd0, Ready}, 128'd0);
    send(32'hFF00_0000);
    send(32'hFAB0_FAB1);
    check("sync_clears_error", {127'd0, ConfigError}, 128'd0);

    // Frame out of range.
    frame(32'h0014_0000, 32'h0000_0005, 32'h0000_0006, 32'h0000_0007, 32'h0000_0008, -1);
    check("frame_oor_strobe", {48'd0, FrameStrobe}, 128'd0);
    check("frame_oor_error", {127'd0, ConfigError}, 128'd1);
    send(32'hFF00_0000);
    send(32'hFAB0_FAB1);
    check("sync_clears_error2", {127'd0, ConfigError}, 128'd0);

    // Back-to-back frames with WriteStrobe held high: bits 39 then 60.
    frame(32'h0113_0000, 32'h0123_4567, 32'h89AB_CDEF, 32'h0F0F_0F0F, 32'hF0F0_F0F0, 39);
    frame(32'h0300_0000, 32'hA0A0_A0A0, 32'hB1B1_B1B1, 32'hC2C2_C2C2, 32'hD3D3_D3D3, 60);
    idle(2);
    check("b2b_spacing", 128'(last_strobe_cyc - prev_strobe_cyc), 128'd6);

    // Desync closes the session; later words are ignored.
    send(32'hFF00_0000);
    check("desync_inactive", {127'd0, ConfigActive}, 128'd0);
    frame(32'h0000_0000, 32'h1, 32'h2, 32'h3, 32'h4, -1);
    check("post_desync_inactive", {127'd0, ConfigActive}, 128'd0);
    check("post_desync_data", FrameData, 128'hD3D3D3D3_C2C2C2C2_B1B1B1B1_A0A0A0A0);

    // Partial frame then reset.
    send(32'hFAB0_FAB1);
    send(32'h0001_0000);
    send(32'h5555_5555);
    send(32'h6666_6666);
    check("partial_rows_keep", FrameData, 128'hD3D3D3D3_C2C2C2C2_66666666_55555555);
    WriteStrobe = 1'b0;
    RESET = 1'b1;
    #1;
    check("midreset_data", FrameData, 128'd0);
    check("midreset_strobe", {48'd0, FrameStrobe}, 128'd0);
    check("midreset_active", {127'd0, ConfigActive}, 128'd0);
    @(negedge CLK);
    RESET = 1'b0;
    @(negedge CLK);
    frame(32'h0203_0000, 32'h7, 32'h8, 32'h9, 32'hA, -1);
    idle(4);
    check("post_reset_inactive", {127'd0, ConfigActive}, 128'd0);
    check("post_reset_data", FrameData, 128'd0);
    check("scoreboard_drained", 128'(sb.size()), 128'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
